// File: rtl/imem_loader.sv
// Framed byte-stream loader for the instruction memory.
// Holds the core in reset until a checksummed frame has been written.
module imem_loader #(
    parameter int ADDR_W  = 7,
    parameter int TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_written
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int TW    = $clog2(TIMEOUT + 1);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [1:0] E_NONE  = 2'd0;
    localparam logic [1:0] E_COUNT = 2'd1;
    localparam logic [1:0] E_SUM   = 2'd2;
    localparam logic [1:0] E_TMO   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_COUNT,
        S_DATA,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_waddr_q;
    logic [31:0]       mem_wdata_q;
    logic              core_reset_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic [1:0]        err_code_q;
    logic [ADDR_W:0]   words_q;
    logic [ADDR_W:0]   count_q;
    logic [1:0]        idx_q;
    logic [23:0]       word_q;
    logic [7:0]        sum_q;
    logic [TW-1:0]     tmo_q;

    logic              accept;
    logic              count_bad;
    logic              tmo_run;
    logic              tmo_hit;
    logic              frame_end;
    logic [31:0]       word_d;
    logic [7:0]        sum_d;

    // Byte acceptance is only offered in the receive states.
    always_comb begin
        in_ready = 1'b0;
        tmo_run  = 1'b0;
        unique case (state_q)
            S_SYNC: begin
                in_ready = 1'b1;
            end
            S_COUNT, S_DATA, S_CHECK: begin
                in_ready = 1'b1;
                tmo_run  = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
                tmo_run  = 1'b0;
            end
        endcase
    end

    assign accept    = in_valid && in_ready;
    assign count_bad = (in_byte == 8'd0)
                    || ({24'd0, in_byte} > 32'(DEPTH));
    assign tmo_hit   = tmo_run && !accept
                    && (tmo_q == TW'(TIMEOUT - 1));
    assign frame_end = (words_q == count_q);
    assign word_d    = {in_byte, word_q};
    assign sum_d     = sum_q + in_byte;

    assign mem_we        = mem_we_q;
    assign mem_waddr     = mem_waddr_q;
    assign mem_wdata     = mem_wdata_q;
    assign core_reset    = core_reset_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign err_code      = err_code_q;
    assign words_written = words_q;

    // Load sequencer: frame parsing, word writes and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            mem_we_q     <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= E_NONE;
            words_q      <= '0;
            count_q      <= '0;
            idx_q        <= '0;
            word_q       <= '0;
            sum_q        <= '0;
            tmo_q        <= '0;
        end else begin
            mem_we_q <= 1'b0;

            // Idle gap counter; any accepted byte or other state clears it.
            if (tmo_run && !accept) begin
                tmo_q <= tmo_q + 1'b1;
            end else begin
                tmo_q <= '0;
            end

            unique case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_q      <= S_SYNC;
                        core_reset_q <= 1'b1;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                        err_code_q   <= E_NONE;
                        words_q      <= '0;
                        mem_waddr_q  <= '0;
                        sum_q        <= '0;
                        idx_q        <= '0;
                    end
                end

                S_SYNC: begin
                    if (accept && (in_byte == SYNC_BYTE)) begin
                        state_q <= S_COUNT;
                    end
                end

                S_COUNT: begin
                    if (tmo_hit) begin
                        state_q    <= S_ERROR;
                        busy_q     <= 1'b0;
                        error_q    <= 1'b1;
                        err_code_q <= E_TMO;
                    end else if (accept) begin
                        if (count_bad) begin
                            state_q    <= S_ERROR;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                            err_code_q <= E_COUNT;
                        end else begin
                            state_q <= S_DATA;
                            count_q <= (ADDR_W + 1)'(in_byte);
                            idx_q   <= '0;
                        end
                    end
                end

                S_DATA: begin
                    if (tmo_hit) begin
                        state_q    <= S_ERROR;
                        busy_q     <= 1'b0;
                        error_q    <= 1'b1;
                        err_code_q <= E_TMO;
                    end else if (accept) begin
                        sum_q <= sum_d;
                        idx_q <= idx_q + 1'b1;
                        if (idx_q == 2'd3) begin
                            state_q     <= S_WRITE;
                            mem_we_q    <= 1'b1;
                            mem_waddr_q <= words_q[ADDR_W-1:0];
                            mem_wdata_q <= word_d;
                            words_q     <= words_q + 1'b1;
                        end else begin
                            word_q[8*idx_q +: 8] <= in_byte;
                        end
                    end
                end

                S_WRITE: begin
                    state_q <= frame_end ? S_CHECK : S_DATA;
                end

                S_CHECK: begin
                    if (tmo_hit) begin
                        state_q    <= S_ERROR;
                        busy_q     <= 1'b0;
                        error_q    <= 1'b1;
                        err_code_q <= E_TMO;
                    end else if (accept) begin
                        busy_q <= 1'b0;
                        if (in_byte == sum_q) begin
                            state_q      <= S_DONE;
                            done_q       <= 1'b1;
                            core_reset_q <= 1'b0;
                        end else begin
                            state_q    <= S_ERROR;
                            error_q    <= 1'b1;
                            err_code_q <= E_SUM;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader.
// Expected writes go into a queue that a negedge monitor drains.
module tb_imem_loader;

    localparam int AW = 7;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    in_byte;
    logic          in_valid;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic          core_reset;
    logic          busy;
    logic          done;
    logic          error;
    logic [1:0]    err_code;
    logic [AW:0]   words_written;

    int checks   = 0;
    int failures = 0;

    logic [AW+31:0] exp_q[$];
    logic [AW+31:0] mon_e;
    logic [7:0]     csum;

    imem_loader #(
        .ADDR_W  (AW),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .in_byte       (in_byte),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .mem_we        (mem_we),
        .mem_waddr     (mem_waddr),
        .mem_wdata     (mem_wdata),
        .core_reset    (core_reset),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .err_code      (err_code),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the queue head.
    always @(negedge clk) begin
        if (!reset && mem_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_we", 64'(mem_we), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 64'(mem_waddr), 64'(mon_e[AW+31:32]));
                chk("wr_data", 64'(mem_wdata), 64'(mon_e[31:0]));
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int n;
        in_byte  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("in_ready_wait", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [AW-1:0] a, input logic [31:0] w);
        exp_q.push_back({a, w});
        for (int k = 0; k < 4; k++) begin
            csum = csum + w[8*k +: 8];
            send(w[8*k +: 8]);
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // {busy, done, error, err_code, core_reset, words_written}
    task automatic status(input string nm, input logic [13:0] exp);
        chk(nm, 64'({busy, done, error, err_code, core_reset, words_written}),
            64'(exp));
        chk({nm, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic reset_vec(input string nm);
        chk(nm, 64'({in_ready, mem_we, mem_waddr, mem_wdata, core_reset,
                     busy, done, error, err_code, words_written}),
            64'({1'b0, 1'b0, 7'd0, 32'd0, 1'b1,
                 1'b0, 1'b0, 1'b0, 2'd0, 8'd0}));
    endtask

    task automatic two_word(input logic [7:0] c);
        csum = 8'd0;
        pulse_start();
        send(8'h00);
        send(8'h7F);
        send(8'hA5);
        send(8'h02);
        send_word(7'd0, 32'h00100093);
        send_word(7'd1, 32'h00200113);
        send(c);
    endtask

    initial begin
        int n;
        logic [31:0] w;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        @(negedge clk);
        reset_vec("reset_state");
        reset = 1'b0;
        @(negedge clk);

        // single word frame
        csum = 8'd0;
        pulse_start();
        chk("t1_started", 64'({busy, core_reset, in_ready}), 64'(3'b111));
        send(8'hA5);
        send(8'h01);
        send_word(7'd0, 32'h00000513);
        chk("t1_we_latency", 64'(mem_we), 64'd1);
        chk("t1_csum_model", 64'(csum), 64'h18);
        chk("t1_core_held", 64'(core_reset), 64'd1);
        send(8'h18);
        status("t1_status", {1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'd1});

        // preamble discarded, two words, good checksum (0xA3 + 0x34)
        two_word(8'hD7);
        status("t2_status", {1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'd2});

        // same frame, bad checksum
        two_word(8'hD8);
        status("t3_status", {1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 8'd2});

        // count of zero
        pulse_start();
        send(8'hA5);
        send(8'h00);
        status("t4_n0", {1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 8'd0});

        // count above depth
        pulse_start();
        send(8'hA5);
        send(8'h81);
        status("t4_n81", {1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 8'd0});

        // full depth
        csum = 8'd0;
        pulse_start();
        send(8'hA5);
        send(8'h80);
        for (int i = 0; i < 128; i++) begin
            w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            send_word(7'(i), w);
        end
        chk("t4_full_csum_model", 64'(csum), 64'h00);
        send(8'h00);
        status("t4_full", {1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'd128});
        chk("t4_last_addr", 64'(mem_waddr), 64'h7F);

        // stall mid-word; start while busy must be ignored
        pulse_start();
        send(8'hA5);
        send(8'h01);
        send(8'h13);
        send(8'h05);
        pulse_start();
        n = 0;
        while (!error && n < TO + 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_tmo_seen", 64'(error), 64'd1);
        status("t5_status", {1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 8'd0});

        // async reset mid-frame, then a clean load
        pulse_start();
        send(8'hA5);
        send(8'h01);
        send(8'h13);
        send(8'h05);
        #1 reset = 1'b1;
        #1 reset_vec("t6_async_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        csum = 8'd0;
        pulse_start();
        send(8'hA5);
        send(8'h01);
        send_word(7'd0, 32'h00100093);
        send(csum);
        status("t6_status", {1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'd1});

        repeat (3) @(negedge clk);
        chk("final_pending", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
